// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_queue
//  Purpose  : Memory-side functional unit of the Tomasulo core. Holds lw/sw
//             operations in program order, snoops the CDB for missing
//             operands and executes the head entry against an internal
//             word-addressed data RAM. Load results return on the CDB through
//             the require/requireAC handshake.
//  Ports    : clk, nRST (async, active-high)
//             WEN/opIn/baseData/baseLabel/storeData/storeLabel/offset - issue
//             BCEN/BClabel/BCdata                                  - CDB snoop
//             requireAC                                            - CDB grant
//             isFull, labelOut                                     - to issue
//             require, resultData, resultLabel                     - to CDB
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_queue #(
    parameter int         DEPTH       = 4,
    parameter logic [3:0] LABEL_BASE  = 4'd12,
    parameter int         MEM_WORDS   = 64,
    parameter int         MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        WEN,
    input  logic        opIn,
    input  logic [31:0] baseData,
    input  logic [3:0]  baseLabel,
    input  logic [31:0] storeData,
    input  logic [3:0]  storeLabel,
    input  logic [31:0] offset,
    input  logic        BCEN,
    input  logic [3:0]  BClabel,
    input  logic [31:0] BCdata,
    input  logic        requireAC,
    output logic        isFull,
    output logic [3:0]  labelOut,
    output logic        require,
    output logic [31:0] resultData,
    output logic [3:0]  resultLabel
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_idx_w = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int c_lat_w = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [c_ptr_w-1:0] c_last_slot = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt  = c_cnt_w'(DEPTH);
    localparam logic [c_lat_w-1:0] c_lat_last  = c_lat_w'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_MEM   = 2'd2,
        ST_BCAST = 2'd3
    } state_t;

    // Queue entry storage
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] op_q,    op_d;
    logic [31:0]      base_q      [DEPTH];
    logic [31:0]      base_d      [DEPTH];
    logic [3:0]       base_lbl_q  [DEPTH];
    logic [3:0]       base_lbl_d  [DEPTH];
    logic [31:0]      store_q     [DEPTH];
    logic [31:0]      store_d     [DEPTH];
    logic [3:0]       store_lbl_q [DEPTH];
    logic [3:0]       store_lbl_d [DEPTH];
    logic [31:0]      off_q       [DEPTH];
    logic [31:0]      off_d       [DEPTH];

    // Pointers, occupancy and execution state
    logic [c_ptr_w-1:0] head_q,  head_d;
    logic [c_ptr_w-1:0] tail_q,  tail_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    state_t             state_q, state_d;
    logic [c_lat_w-1:0] lat_q,   lat_d;
    logic [c_idx_w-1:0] idx_q,   idx_d;
    logic [31:0]        res_data_q,  res_data_d;
    logic [3:0]         res_label_q, res_label_d;

    // Data RAM (not reset)
    logic [31:0] mem_q [MEM_WORDS];

    logic               w_enq;
    logic               w_pop;
    logic               w_mem_we;
    logic               w_head_ready;
    logic [29:0]        w_word;
    logic [c_idx_w-1:0] w_idx;
    logic [3:0]         w_in_store_lbl;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_slot) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign isFull      = (count_q == c_full_cnt);
    assign labelOut    = LABEL_BASE + 4'(tail_q);
    assign require     = (state_q == ST_BCAST);
    assign resultData  = res_data_q;
    assign resultLabel = res_label_q;

    assign w_enq          = WEN && !isFull;
    assign w_head_ready   = valid_q[head_q] && (base_lbl_q[head_q] == 4'd0)
                            && (store_lbl_q[head_q] == 4'd0);
    assign w_in_store_lbl = opIn ? storeLabel : 4'd0;

    // Word address: byte address with the low two bits dropped, folded into RAM
    assign w_word = 30'((base_q[head_q] + off_q[head_q]) >> 2);
    assign w_idx  = c_idx_w'(w_word % 30'(MEM_WORDS));

    always_comb begin
        valid_d     = valid_q;
        op_d        = op_q;
        base_d      = base_q;
        base_lbl_d  = base_lbl_q;
        store_d     = store_q;
        store_lbl_d = store_lbl_q;
        off_d       = off_q;
        head_d      = head_q;
        tail_d      = tail_q;
        state_d     = state_q;
        lat_d       = lat_q;
        idx_d       = idx_q;
        res_data_d  = res_data_q;
        res_label_d = res_label_q;
        w_pop       = 1'b0;
        w_mem_we    = 1'b0;

        // CDB snoop on resident entries
        if (BCEN && (BClabel != 4'd0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (base_lbl_q[i] == BClabel)) begin
                    base_d[i]     = BCdata;
                    base_lbl_d[i] = 4'd0;
                end
                if (valid_q[i] && (store_lbl_q[i] == BClabel)) begin
                    store_d[i]     = BCdata;
                    store_lbl_d[i] = 4'd0;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (w_head_ready) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                idx_d   = w_idx;
                lat_d   = '0;
                state_d = ST_MEM;
            end
            ST_MEM: begin
                if (lat_q == c_lat_last) begin
                    if (op_q[head_q]) begin
                        w_mem_we = 1'b1;
                        w_pop    = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        res_data_d  = mem_q[idx_q];
                        res_label_d = LABEL_BASE + 4'(head_q);
                        state_d     = ST_BCAST;
                    end
                end else begin
                    lat_d = lat_q + c_lat_w'(1);
                end
            end
            ST_BCAST: begin
                // The slot (and thus its tag) is freed only once the CDB accepts
                if (requireAC) begin
                    w_pop   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end

        // The tail slot is never valid while not full, so the enqueue write
        // cannot collide with the snoop or pop updates above.
        if (w_enq) begin
            valid_d[tail_q]     = 1'b1;
            op_d[tail_q]        = opIn;
            off_d[tail_q]       = offset;
            base_d[tail_q]      = baseData;
            base_lbl_d[tail_q]  = baseLabel;
            store_d[tail_q]     = storeData;
            store_lbl_d[tail_q] = w_in_store_lbl;
            if (BCEN && (baseLabel != 4'd0) && (BClabel == baseLabel)) begin
                base_d[tail_q]     = BCdata;
                base_lbl_d[tail_q] = 4'd0;
            end
            if (BCEN && (w_in_store_lbl != 4'd0) && (BClabel == w_in_store_lbl)) begin
                store_d[tail_q]     = BCdata;
                store_lbl_d[tail_q] = 4'd0;
            end
            tail_d = ptr_inc(tail_q);
        end

        count_d = count_q + c_cnt_w'(w_enq) - c_cnt_w'(w_pop);
    end

    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            valid_q     <= '0;
            op_q        <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            idx_q       <= '0;
            res_data_q  <= '0;
            res_label_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                base_q[i]      <= '0;
                base_lbl_q[i]  <= '0;
                store_q[i]     <= '0;
                store_lbl_q[i] <= '0;
                off_q[i]       <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            base_q      <= base_d;
            base_lbl_q  <= base_lbl_d;
            store_q     <= store_d;
            store_lbl_q <= store_lbl_d;
            off_q       <= off_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            state_q     <= state_d;
            lat_q       <= lat_d;
            idx_q       <= idx_d;
            res_data_q  <= res_data_d;
            res_label_q <= res_label_d;
        end
    end

    // Reset forces IDLE, which deasserts the write enable, so an in-flight
    // store is dropped rather than committed.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[idx_q] <= store_q[head_q];
        end
    end

endmodule
`default_nettype wire
